// File: rtl/ecc_mon_pkg.sv
// Shared types and constants for the ECC error monitor.
// Contents: error-record layout, event classification enum, log syndrome width.
// The record address width below is the default that the top-level log record matches.
package ecc_mon_pkg;

    // Default width of the address/tag stored in each log record.
    localparam int REC_ADDR_WIDTH = 16;

    // Only the low syndrome bits are kept in the log; the full syndrome is
    // retained for the first UE only.
    localparam int SYN_LOG_W = 8;

    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_CE   = 2'd1,
        EVT_UE   = 2'd2
    } ecc_evt_e;

    typedef struct packed {
        logic                      is_ue;
        logic [REC_ADDR_WIDTH-1:0] addr;
        logic [SYN_LOG_W-1:0]      syn;
        logic [7:0]                pos;
    } ecc_err_rec_t;

endpackage

// File: rtl/ecc_mon_fifo.sv
// Generic show-ahead FIFO: head entry is always presented on rd_dat while rd_vld=1.
// Latency: a push into an empty FIFO is visible on rd_vld/rd_dat the next cycle.
// Backpressure: push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
// Ports: clk, rst_n, clr (sync clear of pointers), push/wr_dat, pop, rd_vld/rd_dat, full.
module ecc_mon_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // accept a simultaneous push; a pop on an empty FIFO is simply ignored.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is reset so the head output reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !clr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
        end
    end

    assign rd_vld = !empty;
    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ecc_err_monitor.sv
// Classifies SECDED decode results as CE/UE, keeps saturating counters, a first-UE sticky and an error log.
// Latency: counters, stickies and irqs update on the edge after the event; log head valid one cycle after a push.
// Backpressure: none upstream; events arriving while the log is full are dropped from the log and flagged sticky.
// Ports: decoder status in (dec_*), config (cfg_*), log pop/read, counters, first-UE capture, irq_ce/irq_ue.
module ecc_err_monitor #(
    parameter int LOG_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dec_valid,
    input  logic [ADDR_WIDTH-1:0]    dec_addr,
    input  logic                     dec_single_err,
    input  logic                     dec_double_err,
    input  logic [15:0]              dec_syndrome,
    input  logic [7:0]               dec_err_pos,
    input  logic [CNT_WIDTH-1:0]     cfg_ce_threshold,
    input  logic                     cfg_clear,
    input  logic                     log_rd_en,
    output logic                     log_valid,
    output logic [ADDR_WIDTH+16:0]   log_data,
    output logic                     log_overflow,
    output logic [CNT_WIDTH-1:0]     ce_count,
    output logic [CNT_WIDTH-1:0]     ue_count,
    output logic                     first_ue_valid,
    output logic [ADDR_WIDTH-1:0]    first_ue_addr,
    output logic [15:0]              first_ue_syn,
    output logic                     irq_ce,
    output logic                     irq_ue
);

    import ecc_mon_pkg::*;

    localparam int REC_W = 1 + ADDR_WIDTH + SYN_LOG_W + 8;

    ecc_evt_e              evt;
    logic [CNT_WIDTH-1:0]  ce_cnt_q, ce_cnt_d;
    logic [CNT_WIDTH-1:0]  ue_cnt_q, ue_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  fue_vld_q, fue_vld_d;
    logic [ADDR_WIDTH-1:0] fue_addr_q, fue_addr_d;
    logic [15:0]           fue_syn_q, fue_syn_d;
    logic                  irq_ce_q, irq_ce_d;
    logic                  log_push;
    logic                  log_pop;
    logic                  log_full;
    logic [REC_W-1:0]      log_wr_dat;

    // A double-error flag dominates: both flags set is a UE only.
    always_comb begin
        evt = EVT_NONE;
        if (dec_valid) begin
            if (dec_double_err)      evt = EVT_UE;
            else if (dec_single_err) evt = EVT_CE;
        end
    end

    // Clear wins over any coincident event or pop.
    assign log_push   = (evt != EVT_NONE) && !cfg_clear;
    assign log_pop    = log_rd_en && !cfg_clear;
    assign log_wr_dat = {evt == EVT_UE, dec_addr, dec_syndrome[SYN_LOG_W-1:0], dec_err_pos};

    always_comb begin
        ce_cnt_d   = ce_cnt_q;
        ue_cnt_d   = ue_cnt_q;
        ovf_d      = ovf_q;
        fue_vld_d  = fue_vld_q;
        fue_addr_d = fue_addr_q;
        fue_syn_d  = fue_syn_q;
        if (cfg_clear) begin
            ce_cnt_d  = '0;
            ue_cnt_d  = '0;
            ovf_d     = 1'b0;
            fue_vld_d = 1'b0;
        end else begin
            if (evt == EVT_CE && ce_cnt_q != '1) ce_cnt_d = ce_cnt_q + CNT_WIDTH'(1);
            if (evt == EVT_UE && ue_cnt_q != '1) ue_cnt_d = ue_cnt_q + CNT_WIDTH'(1);
            // When full, log_valid is high, so log_rd_en alone means a real pop.
            if (evt != EVT_NONE && log_full && !log_rd_en) ovf_d = 1'b1;
            if (evt == EVT_UE && !fue_vld_q) begin
                fue_vld_d  = 1'b1;
                fue_addr_d = dec_addr;
                fue_syn_d  = dec_syndrome;
            end
        end
        // Compare against the next count so the irq lines up with the counter,
        // and against the live threshold so config changes apply next cycle.
        irq_ce_d = (cfg_ce_threshold != '0) && (ce_cnt_d >= cfg_ce_threshold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_cnt_q   <= '0;
            ue_cnt_q   <= '0;
            ovf_q      <= 1'b0;
            fue_vld_q  <= 1'b0;
            fue_addr_q <= '0;
            fue_syn_q  <= '0;
            irq_ce_q   <= 1'b0;
        end else begin
            ce_cnt_q   <= ce_cnt_d;
            ue_cnt_q   <= ue_cnt_d;
            ovf_q      <= ovf_d;
            fue_vld_q  <= fue_vld_d;
            fue_addr_q <= fue_addr_d;
            fue_syn_q  <= fue_syn_d;
            irq_ce_q   <= irq_ce_d;
        end
    end

    ecc_mon_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (REC_W)
    ) u_log (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cfg_clear),
        .push   (log_push),
        .wr_dat (log_wr_dat),
        .pop    (log_pop),
        .rd_vld (log_valid),
        .rd_dat (log_data),
        .full   (log_full)
    );

    assign log_overflow   = ovf_q;
    assign ce_count       = ce_cnt_q;
    assign ue_count       = ue_cnt_q;
    assign first_ue_valid = fue_vld_q;
    assign first_ue_addr  = fue_addr_q;
    assign first_ue_syn   = fue_syn_q;
    assign irq_ce         = irq_ce_q;
    assign irq_ue         = (ue_cnt_q != '0);

endmodule

// File: tb/tb_ecc_err_monitor.sv
// Directed self-checking bench for ecc_err_monitor.
// A second instance with 4-bit counters shares the stimulus to check saturation.
// Outputs are sampled 1 time unit after the rising edge.
module tb_ecc_err_monitor;

    logic        clk;
    logic        rst_n;
    logic        dec_valid;
    logic [15:0] dec_addr;
    logic        dec_single_err;
    logic        dec_double_err;
    logic [15:0] dec_syndrome;
    logic [7:0]  dec_err_pos;
    logic [15:0] cfg_ce_threshold;
    logic [3:0]  thr4;
    logic        cfg_clear;
    logic        log_rd_en;

    logic        log_valid;
    logic [32:0] log_data;
    logic        log_overflow;
    logic [15:0] ce_count;
    logic [15:0] ue_count;
    logic        first_ue_valid;
    logic [15:0] first_ue_addr;
    logic [15:0] first_ue_syn;
    logic        irq_ce;
    logic        irq_ue;

    logic        log_valid4;
    logic [32:0] log_data4;
    logic        log_overflow4;
    logic [3:0]  ce_count4;
    logic [3:0]  ue_count4;
    logic        first_ue_valid4;
    logic [15:0] first_ue_addr4;
    logic [15:0] first_ue_syn4;
    logic        irq_ce4;
    logic        irq_ue4;

    int total = 0;
    int bad   = 0;

    ecc_err_monitor #(.LOG_DEPTH(4), .CNT_WIDTH(16), .ADDR_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_addr(dec_addr),
        .dec_single_err(dec_single_err), .dec_double_err(dec_double_err),
        .dec_syndrome(dec_syndrome), .dec_err_pos(dec_err_pos),
        .cfg_ce_threshold(cfg_ce_threshold), .cfg_clear(cfg_clear), .log_rd_en(log_rd_en),
        .log_valid(log_valid), .log_data(log_data), .log_overflow(log_overflow),
        .ce_count(ce_count), .ue_count(ue_count), .first_ue_valid(first_ue_valid),
        .first_ue_addr(first_ue_addr), .first_ue_syn(first_ue_syn),
        .irq_ce(irq_ce), .irq_ue(irq_ue)
    );

    ecc_err_monitor #(.LOG_DEPTH(4), .CNT_WIDTH(4), .ADDR_WIDTH(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_addr(dec_addr),
        .dec_single_err(dec_single_err), .dec_double_err(dec_double_err),
        .dec_syndrome(dec_syndrome), .dec_err_pos(dec_err_pos),
        .cfg_ce_threshold(thr4), .cfg_clear(cfg_clear), .log_rd_en(log_rd_en),
        .log_valid(log_valid4), .log_data(log_data4), .log_overflow(log_overflow4),
        .ce_count(ce_count4), .ue_count(ue_count4), .first_ue_valid(first_ue_valid4),
        .first_ue_addr(first_ue_addr4), .first_ue_syn(first_ue_syn4),
        .irq_ce(irq_ce4), .irq_ue(irq_ue4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] rec(input logic ue, input logic [15:0] a,
                                        input logic [7:0] s, input logic [7:0] p);
        return {ue, a, s, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid      = 1'b0;
        dec_single_err = 1'b0;
        dec_double_err = 1'b0;
        log_rd_en      = 1'b0;
        cfg_clear      = 1'b0;
    endtask

    // One decode result presented for one cycle, optionally with a pop.
    task automatic ev(input logic s, input logic d, input logic [15:0] a,
                      input logic [15:0] syn, input logic [7:0] pos, input logic rd);
        dec_valid      = 1'b1;
        dec_single_err = s;
        dec_double_err = d;
        dec_addr       = a;
        dec_syndrome   = syn;
        dec_err_pos    = pos;
        log_rd_en      = rd;
        tick();
        idle();
    endtask

    task automatic pop();
        log_rd_en = 1'b1;
        tick();
        idle();
    endtask

    task automatic clear();
        cfg_clear = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        dec_addr         = '0;
        dec_syndrome     = '0;
        dec_err_pos      = '0;
        cfg_ce_threshold = 16'd3;
        thr4             = 4'd15;
        rst_n            = 1'b0;
        #12;
        // Reset state
        chk("rst_log_valid", 64'(log_valid), 64'd0);
        chk("rst_log_data", 64'(log_data), 64'd0);
        chk("rst_ce", 64'(ce_count), 64'd0);
        chk("rst_ue", 64'(ue_count), 64'd0);
        chk("rst_ovf", 64'(log_overflow), 64'd0);
        chk("rst_fue", 64'(first_ue_valid), 64'd0);
        chk("rst_irqs", 64'({irq_ce, irq_ue}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three CEs reaching the threshold of 3
        ev(1'b1, 1'b0, 16'h0010, 16'h0020, 8'h01, 1'b0);
        ev(1'b1, 1'b0, 16'h0011, 16'h0021, 8'h02, 1'b0);
        chk("ce2_count", 64'(ce_count), 64'd2);
        chk("ce2_irq", 64'(irq_ce), 64'd0);
        ev(1'b1, 1'b0, 16'h0012, 16'h0022, 8'h03, 1'b0);
        chk("ce3_count", 64'(ce_count), 64'd3);
        chk("ce3_irq", 64'(irq_ce), 64'd1);
        chk("ce3_irq_ue", 64'(irq_ue), 64'd0);

        // Live threshold changes
        cfg_ce_threshold = 16'd4; tick();
        chk("thr4_irq", 64'(irq_ce), 64'd0);
        cfg_ce_threshold = 16'd3; tick();
        chk("thr3_irq", 64'(irq_ce), 64'd1);
        cfg_ce_threshold = 16'd0; tick();
        chk("thr0_irq", 64'(irq_ce), 64'd0);
        cfg_ce_threshold = 16'd3; tick();

        // Log contents in order
        chk("log0_vld", 64'(log_valid), 64'd1);
        chk("log0", 64'(log_data), 64'(rec(1'b0, 16'h0010, 8'h20, 8'h01)));
        pop();
        chk("log1", 64'(log_data), 64'(rec(1'b0, 16'h0011, 8'h21, 8'h02)));
        pop();
        chk("log2", 64'(log_data), 64'(rec(1'b0, 16'h0012, 8'h22, 8'h03)));
        pop();
        chk("log_drained", 64'(log_valid), 64'd0);

        // UE with both flags set
        clear();
        chk("clr_ce", 64'(ce_count), 64'd0);
        ev(1'b1, 1'b1, 16'h00AB, 16'h0105, 8'h00, 1'b0);
        chk("ue1_count", 64'(ue_count), 64'd1);
        chk("ue1_ce", 64'(ce_count), 64'd0);
        chk("ue1_irq_ue", 64'(irq_ue), 64'd1);
        chk("ue1_fue_vld", 64'(first_ue_valid), 64'd1);
        chk("ue1_fue_addr", 64'(first_ue_addr), 64'h00AB);
        chk("ue1_fue_syn", 64'(first_ue_syn), 64'h0105);
        ev(1'b0, 1'b1, 16'h00CD, 16'h0203, 8'h07, 1'b0);
        chk("ue2_count", 64'(ue_count), 64'd2);
        chk("ue2_fue_addr", 64'(first_ue_addr), 64'h00AB);
        chk("ue2_fue_syn", 64'(first_ue_syn), 64'h0105);
        chk("ue_log0", 64'(log_data), 64'(rec(1'b1, 16'h00AB, 8'h05, 8'h00)));
        pop();
        chk("ue_log1", 64'(log_data), 64'(rec(1'b1, 16'h00CD, 8'h03, 8'h07)));
        pop();

        // Overflow: 5 CEs, no pops
        clear();
        for (int i = 0; i < 5; i++)
            ev(1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0030 + 16'(i), 8'h40 + 8'(i), 1'b0);
        chk("ovf_ce", 64'(ce_count), 64'd5);
        chk("ovf_flag", 64'(log_overflow), 64'd1);
        chk("ovf_head", 64'(log_data), 64'(rec(1'b0, 16'h0100, 8'h30, 8'h40)));
        // Push + pop while full
        ev(1'b1, 1'b0, 16'h0200, 16'h0055, 8'h66, 1'b1);
        chk("fullpp_ce", 64'(ce_count), 64'd6);
        chk("fullpp_head", 64'(log_data), 64'(rec(1'b0, 16'h0101, 8'h31, 8'h41)));
        pop();
        chk("fullpp_e2", 64'(log_data), 64'(rec(1'b0, 16'h0102, 8'h32, 8'h42)));
        pop();
        chk("fullpp_e3", 64'(log_data), 64'(rec(1'b0, 16'h0103, 8'h33, 8'h43)));
        pop();
        chk("fullpp_tail", 64'(log_data), 64'(rec(1'b0, 16'h0200, 8'h55, 8'h66)));
        chk("fullpp_tail_vld", 64'(log_valid), 64'd1);
        pop();
        chk("fullpp_empty", 64'(log_valid), 64'd0);
        chk("ovf_sticky", 64'(log_overflow), 64'd1);
        // Push + pop while empty: push kept
        ev(1'b1, 1'b0, 16'h0300, 16'h0077, 8'h88, 1'b1);
        chk("emptypp_vld", 64'(log_valid), 64'd1);
        chk("emptypp_head", 64'(log_data), 64'(rec(1'b0, 16'h0300, 8'h77, 8'h88)));
        pop();

        // Saturation on the 4-bit instance
        clear();
        chk("sat_clr4", 64'(ce_count4), 64'd0);
        for (int i = 0; i < 17; i++)
            ev(1'b1, 1'b0, 16'h0400 + 16'(i), 16'h0001, 8'h01, 1'b0);
        chk("sat_ce16", 64'(ce_count), 64'd17);
        chk("sat_ce4", 64'(ce_count4), 64'd15);
        chk("sat_irq4", 64'(irq_ce4), 64'd1);

        // Clear coincident with UE and pop
        ev(1'b0, 1'b1, 16'h0500, 16'h0099, 8'h09, 1'b0);
        chk("preclr_ue", 64'(ue_count), 64'd1);
        cfg_clear      = 1'b1;
        dec_valid      = 1'b1;
        dec_double_err = 1'b1;
        dec_addr       = 16'h0600;
        log_rd_en      = 1'b1;
        tick();
        idle();
        chk("clr_ce_all", 64'(ce_count), 64'd0);
        chk("clr_ue_all", 64'(ue_count), 64'd0);
        chk("clr_log_vld", 64'(log_valid), 64'd0);
        chk("clr_fue", 64'(first_ue_valid), 64'd0);
        chk("clr_irqs", 64'({irq_ce, irq_ue}), 64'd0);
        chk("clr_ovf", 64'(log_overflow), 64'd0);
        tick();
        chk("clr_ue_later", 64'(ue_count), 64'd0);

        // Asynchronous reset mid-burst
        ev(1'b1, 1'b0, 16'h0700, 16'h0011, 8'h02, 1'b0);
        ev(1'b0, 1'b1, 16'h0701, 16'h0012, 8'h03, 1'b0);
        chk("prerst_ue", 64'(ue_count), 64'd1);
        dec_valid      = 1'b1;
        dec_single_err = 1'b1;
        dec_addr       = 16'h0702;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ce", 64'(ce_count), 64'd0);
        chk("arst_ue", 64'(ue_count), 64'd0);
        chk("arst_log_vld", 64'(log_valid), 64'd0);
        chk("arst_log_data", 64'(log_data), 64'd0);
        chk("arst_fue", 64'(first_ue_valid), 64'd0);
        chk("arst_irqs", 64'({irq_ce, irq_ue}), 64'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ce", 64'(ce_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
